crd_hold: RTL and testbench
===========================

# crd_hold

Sparse-pipeline coordinate-hold primitive. It consumes an inner coordinate stream and an outer coordinate stream, forwards the inner stream unchanged, and repeats the current outer coordinate once per inner token. This aligns outer coordinates with the inner iteration space. It sits between a level scanner pair and downstream intersect/compute units, and uses ready/valid streams carrying 17-bit tokens.

## Interface
- No parameters. Token width is fixed at 17.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  when 0, all state (FSM and FIFOs) holds.
- flush  in  1  synchronous clear to the post-reset state.
- tile_en  in  1  when 0, all valid/ready outputs are forced to 0 and no state advances.
- cmrg_enable  in  1  ignored.
- cmrg_stop_lvl  in  16  ignored.
- cmrg_coord_in_0, _valid, _ready  in/in/out  17/1/1  inner stream.
- cmrg_coord_in_1, _valid, _ready  in/in/out  17/1/1  outer stream.
- cmrg_coord_out_0, _valid, _ready  out/out/in  17/1/1  inner passthrough.
- cmrg_coord_out_1, _valid, _ready  out/out/in  17/1/1  held outer coordinate.

## Operation
- Token encoding:
  - bit16=0: data, with coordinate in [15:0].
  - bit16=1 and [9:8]=00: stop token S_n, with level n in [7:0].
  - bit16=1 and [9:8]=01: done token, 17'h10100.
- Every input and output has a 2-entry FIFO.
  - Input ready = input FIFO not full.
  - Output valid = output FIFO not empty.
- An emit step requires:
  - the inner FIFO is non-empty;
  - the outer FIFO is non-empty;
  - both output FIFOs have space.
- An emit step writes both output FIFOs in the same cycle.
- FSM states: PROC, POP_OSTOP, DONE.
- PROC, inner head is data d, outer head is data o:
  - emit (d, o);
  - pop inner only.
- PROC, inner head is S_n:
  - emit (S_n, S_n) and pop inner.
  - If the outer head is data: pop it; if n>0, go to POP_OSTOP.
  - If the outer head is a stop (empty outer fiber): pop it; no extra pop.
- POP_OSTOP: when the outer head is valid, pop it (expected S_{n-1}; not emitted), then return to PROC.
- PROC, inner head is done:
  - wait for the outer head to be done;
  - emit (done, done), pop both, go to DONE.
- DONE: no pops. Return to PROC on flush, or on the next cycle when the inner FIFO is non-empty, to allow multiple transactions.
- Inner data arriving while the outer head is a stop/done token is a protocol error. Required behaviour: stall; no emit, no pop.

## Timing
- Reset/flush values:
  - all FIFOs empty;
  - FSM = PROC;
  - out data = 0, out valid = 0;
  - in ready = 1 once rst_n is high and tile_en=1.
- Latency is 2 cycles (input FIFO write, then output FIFO write).
- Throughput is 1 inner token per cycle when outputs are not stalled.
- Input handshake occurs on valid & ready at the rising edge. Data must be held while valid & !ready.
- Output data and valid are stable until ready is sampled.
- FIFO simultaneous push and pop:
  - when full, the pop frees space in the same cycle, so ready stays high;
  - when empty, there is no bypass.
- Backpressure on either output stalls both outputs (lockstep).
- Async reset mid-stream: everything returns to reset values immediately.

## Structure
- Package crd_pkg: TOKEN_W=17, DONE_TOKEN=17'h10100, is_data/is_stop/is_done/stop_lvl functions, and an FSM state enum.
- Sub-module reg_fifo (depth 2, width 17), instantiated 4 times.
- Top: FSM plus emit/pop logic.

## Test plan
- Basic:
  - inner = [2, 5, 0x10000, 3, 0x10001, 0x10100];
  - outer = [0, 1, 0x10000, 0x10100];
  - required out_0 = inner;
  - required out_1 = [0, 0, 0x10000, 1, 0x10001, 0x10100].
- Empty inner fiber:
  - inner = [0x10000, 7, 0x10001, D];
  - outer = [4, 9, 0x10000, D];
  - required out_1 = [0x10000, 9, 0x10001, D].
- Backpressure:
  - random out ready (50%) on the basic case;
  - identical sequences required; out_0/out_1 valid always equal; no token dropped or duplicated.
- Skewed arrival:
  - outer stream delayed 20 cycles;
  - no emit until the outer head is valid;
  - inner ready drops after 2 tokens are buffered.
- Reset/flush mid-stream:
  - assert flush after 3 tokens;
  - all valids go to 0 next cycle;
  - rerunning the basic case gives the same results.
- Throughput: 100 inner data tokens with one outer coordinate → 100 outputs within 102 cycles of the first valid.

Source files
------------

// File: rtl/crd_hold_pkg.sv
// Shared token types and decode helpers for the coordinate-hold primitive.
// Tokens are 17 bits: bit16 clear for data, set for control (stop/done).
package crd_pkg;

  localparam int TOKEN_W = 17;
  localparam logic [TOKEN_W-1:0] DONE_TOKEN = 17'h10100;

  typedef logic [TOKEN_W-1:0] token_t;

  typedef enum logic [1:0] {
    PROC      = 2'd0,
    POP_OSTOP = 2'd1,
    DONE      = 2'd2
  } state_t;

  function automatic logic is_done(input token_t t);
    return t == DONE_TOKEN;
  endfunction

  // Done never has [9:8]=00 or bit16=0, so the extra is_done term is a no-op
  // that keeps every token bit referenced.
  function automatic logic is_stop(input token_t t);
    return t[16] && (t[9:8] == 2'b00) && !is_done(t);
  endfunction

  function automatic logic is_data(input token_t t);
    return !t[16] && !is_done(t);
  endfunction

  function automatic logic [7:0] stop_lvl(input token_t t);
    return is_done(t) ? 8'd0 : t[7:0];
  endfunction

endpackage

// File: rtl/crd_hold_if.sv
// Ready/valid token stream carrying one 17-bit coordinate token.
interface crd_stream_if;
  crd_pkg::token_t data;
  logic            valid;
  logic            ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/crd_hold_fifo.sv
// Two-entry register FIFO, no bypass; head is always a registered value.
module reg_fifo
  import crd_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   clr,
  input  logic   push,
  input  logic   pop,
  input  token_t din,
  output token_t dout,
  output logic   full,
  output logic   empty
);

  token_t [1:0] mem;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         wr_ptr;

  assign wr_ptr = rd_ptr ^ count[0];
  assign dout   = mem[rd_ptr];
  assign full   = (count == 2'd2);
  assign empty  = (count == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (en) begin
      if (clr) begin
        mem    <= '0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) mem[wr_ptr] <= din;
        if (pop)  rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: rtl/crd_hold.sv
// Coordinate hold: forwards the inner stream and repeats the current outer
// coordinate once per inner token; both outputs move in lockstep.
module crd_hold
  import crd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        flush,
  input  logic        tile_en,
  input  logic        cmrg_enable,
  input  logic [15:0] cmrg_stop_lvl,
  crd_stream_if.slave  cmrg_coord_in_0,
  crd_stream_if.slave  cmrg_coord_in_1,
  crd_stream_if.master cmrg_coord_out_0,
  crd_stream_if.master cmrg_coord_out_1
);

  logic unused_cfg;
  assign unused_cfg = ^{cmrg_enable, cmrg_stop_lvl};

  logic act, go;
  assign act = clk_en & tile_en;
  assign go  = act & ~flush;

  token_t [1:0] in_din, in_head, out_din, out_head;
  logic   [1:0] in_vld, in_rdy, in_push, in_pop, in_full, in_empty;
  logic   [1:0] out_rdy, out_full, out_empty;
  logic         out_pop, out_space, emit, pop_i, pop_o;
  token_t       emit_d0, emit_d1;

  assign in_din = {cmrg_coord_in_1.data, cmrg_coord_in_0.data};
  assign in_vld = {cmrg_coord_in_1.valid, cmrg_coord_in_0.valid};
  assign cmrg_coord_in_0.ready = in_rdy[0];
  assign cmrg_coord_in_1.ready = in_rdy[1];

  assign out_rdy = {cmrg_coord_out_1.ready, cmrg_coord_out_0.ready};
  assign cmrg_coord_out_0.data  = out_head[0];
  assign cmrg_coord_out_1.data  = out_head[1];
  assign cmrg_coord_out_0.valid = act & ~out_empty[0];
  assign cmrg_coord_out_1.valid = act & ~out_empty[1];

  // Outputs drain as a pair; either side stalling holds both.
  assign out_pop   = act & ~out_empty[0] & ~out_empty[1] & (&out_rdy);
  assign out_space = (~out_full[0] | out_pop) & (~out_full[1] | out_pop);
  assign in_pop    = {pop_o, pop_i};
  assign out_din   = {emit_d1, emit_d0};

  for (genvar i = 0; i < 2; i++) begin : g_in
    assign in_rdy[i]  = go & (~in_full[i] | in_pop[i]);
    assign in_push[i] = in_vld[i] & in_rdy[i];
    reg_fifo u_fifo (
      .clk(clk), .rst_n(rst_n), .en(clk_en), .clr(flush),
      .push(in_push[i]), .pop(in_pop[i]), .din(in_din[i]),
      .dout(in_head[i]), .full(in_full[i]), .empty(in_empty[i])
    );
  end

  for (genvar i = 0; i < 2; i++) begin : g_out
    reg_fifo u_fifo (
      .clk(clk), .rst_n(rst_n), .en(clk_en), .clr(flush),
      .push(emit), .pop(out_pop), .din(out_din[i]),
      .dout(out_head[i]), .full(out_full[i]), .empty(out_empty[i])
    );
  end

  state_t st, nxt;
  token_t ih, oh;
  logic   both_vld;
  assign ih       = in_head[0];
  assign oh       = in_head[1];
  assign both_vld = ~in_empty[0] & ~in_empty[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      st <= PROC;
    else if (clk_en) st <= flush ? PROC : nxt;
  end

  always_comb begin
    nxt     = st;
    emit    = 1'b0;
    pop_i   = 1'b0;
    pop_o   = 1'b0;
    emit_d0 = ih;
    emit_d1 = oh;
    case (st)
      PROC: begin
        if (go && both_vld && out_space) begin
          if (is_data(ih)) begin
            // Inner data against a control outer head is a protocol error: stall.
            if (is_data(oh)) begin
              emit  = 1'b1;
              pop_i = 1'b1;
            end
          end else if (is_stop(ih)) begin
            if (is_data(oh) || is_stop(oh)) begin
              emit    = 1'b1;
              emit_d1 = ih;
              pop_i   = 1'b1;
              pop_o   = 1'b1;
              // Closing a non-empty outer fiber leaves S_{n-1} to discard.
              if (is_data(oh) && stop_lvl(ih) != 8'd0) nxt = POP_OSTOP;
            end
          end else if (is_done(ih) && is_done(oh)) begin
            emit  = 1'b1;
            pop_i = 1'b1;
            pop_o = 1'b1;
            nxt   = DONE;
          end
        end
      end
      POP_OSTOP: begin
        if (go && !in_empty[1]) begin
          pop_o = 1'b1;
          nxt   = PROC;
        end
      end
      DONE: begin
        if (go && !in_empty[0]) nxt = PROC;
      end
      default: nxt = PROC;
    endcase
  end

endmodule

// File: tb/tb_crd_hold.sv
// Randomized scoreboard bench for crd_hold against a token-level stream model.
module tb_crd_hold;

  typedef logic [16:0] tok_t;
  localparam tok_t TD = 17'h10100;

  logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, flush = 1'b0, tile_en = 1'b1;
  logic cmrg_enable = 1'b0;
  logic [15:0] cmrg_stop_lvl = 16'h0;

  crd_stream_if in0(), in1(), out0(), out1();

  crd_hold dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .cmrg_enable(cmrg_enable), .cmrg_stop_lvl(cmrg_stop_lvl),
    .cmrg_coord_in_0(in0), .cmrg_coord_in_1(in1),
    .cmrg_coord_out_0(out0), .cmrg_coord_out_1(out1)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int rdy_pct = 100;
  bit mon_en = 1'b1, tp_arm = 1'b0;
  int tp_first = -1, tp_last = -1, tp_cnt = 0;
  tok_t exp0[$], exp1[$];

  tok_t bi[$] = '{17'h2, 17'h5, 17'h10000, 17'h3, 17'h10001, 17'h10100};
  tok_t bo[$] = '{17'h0, 17'h1, 17'h10000, 17'h10100};
  tok_t b1[$] = '{17'h0, 17'h0, 17'h10000, 17'h1, 17'h10001, 17'h10100};
  tok_t ei[$] = '{17'h10000, 17'h7, 17'h10001, 17'h10100};
  tok_t eo[$] = '{17'h4, 17'h9, 17'h10000, 17'h10100};
  tok_t e1x[$] = '{17'h10000, 17'h9, 17'h10001, 17'h10100};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic set_in(input int s, input logic v, input tok_t d);
    if (s == 0) begin in0.valid = v; in0.data = d; end
    else begin in1.valid = v; in1.data = d; end
  endtask

  function automatic logic get_rdy(input int s);
    return (s == 0) ? in0.ready : in1.ready;
  endfunction

  task automatic drive(input int s, input tok_t toks[$], input int gap_pct, input int delay);
    bit acc;
    int n;
    repeat (delay) @(posedge clk);
    @(posedge clk); #1;
    foreach (toks[k]) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        set_in(s, 1'b0, toks[k]);
        @(posedge clk); #1;
      end
      set_in(s, 1'b1, toks[k]);
      n = 0;
      acc = 1'b0;
      while (!acc && n < 2000) begin
        @(negedge clk);
        acc = get_rdy(s);
        n++;
        if (!acc) begin @(posedge clk); #1; end
      end
      if (!acc) begin
        checks++; failures++;
        $display("FAIL drive_timeout stream=%0d token=%0d actual=stalled required=accepted", s, k);
        break;
      end
      @(posedge clk); #1;
    end
    set_in(s, 1'b0, '0);
  endtask

  // Token-level reference: walk the inner stream, holding an index into outer.
  task automatic model(input tok_t inr[$], input tok_t outr[$], output tok_t m0[$], output tok_t m1[$]);
    int j = 0;
    tok_t t;
    m0.delete(); m1.delete();
    foreach (inr[k]) begin
      t = inr[k];
      if (j >= outr.size()) break;
      if (!t[16]) begin
        m0.push_back(t); m1.push_back(outr[j]);
      end else if (t == TD) begin
        m0.push_back(t); m1.push_back(t); j++;
      end else begin
        m0.push_back(t); m1.push_back(t);
        j += (!outr[j][16] && t[7:0] != 8'd0) ? 2 : 1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp0.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    checks++;
    if (exp0.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d_pending required=0", exp0.size());
      exp0.delete(); exp1.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic run_case(input tok_t inr[$], input tok_t outr[$], input tok_t e0[$],
                          input tok_t e1[$], input int gap, input int odly);
    foreach (e0[k]) begin exp0.push_back(e0[k]); exp1.push_back(e1[k]); end
    fork
      drive(0, inr, gap, 0);
      drive(1, outr, gap, odly);
    join
    drain();
  endtask

  task automatic gen(output tok_t gi[$], output tok_t go[$]);
    int m;
    gi.delete(); go.delete();
    m = $urandom_range(1, 4);
    for (int i = 0; i < m; i++) begin
      go.push_back(tok_t'($urandom_range(0, 16'hffff)));
      for (int l = $urandom_range(0, 3); l > 0; l--)
        gi.push_back(tok_t'($urandom_range(0, 16'hffff)));
      gi.push_back((i == m - 1) ? 17'h10001 : 17'h10000);
    end
    go.push_back(17'h10000);
    gi.push_back(TD); go.push_back(TD);
  endtask

  initial forever begin @(posedge clk); cyc++; end

  initial begin
    logic r;
    out0.ready = 1'b0; out1.ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      r = ($urandom_range(0, 99) < rdy_pct);
      out0.ready = r; out1.ready = r;
    end
  end

  initial begin
    tok_t pd0, pd1, e0, e1;
    bit pstall;
    pstall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en) begin
        chk("lockstep_valid", 32'(out1.valid), 32'(out0.valid));
        if (pstall) begin
          chk("hold_valid", 32'(out0.valid), 32'd1);
          chk("hold_out0", 32'(out0.data), 32'(pd0));
          chk("hold_out1", 32'(out1.data), 32'(pd1));
        end
        pstall = out0.valid && !out0.ready;
        pd0 = out0.data; pd1 = out1.data;
        if (tp_arm && out0.valid && tp_first < 0) tp_first = cyc;
        if (out0.valid && out0.ready) begin
          if (exp0.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output actual=%h/%h required=none", out0.data, out1.data);
          end else begin
            e0 = exp0.pop_front(); e1 = exp1.pop_front();
            chk("out0_data", 32'(out0.data), 32'(e0));
            chk("out1_data", 32'(out1.data), 32'(e1));
          end
          if (tp_arm) begin
            tp_cnt++;
            if (tp_cnt == 100) tp_last = cyc;
          end
        end
      end else pstall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    tok_t gi[$], go[$], m0[$], m1[$];
    in0.valid = 1'b0; in0.data = '0; in1.valid = 1'b0; in1.data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out0_valid", 32'(out0.valid), 32'd0);
    chk("rst_out1_valid", 32'(out1.valid), 32'd0);
    chk("rst_out0_data", 32'(out0.data), 32'd0);
    chk("rst_out1_data", 32'(out1.data), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in0_ready", 32'(in0.ready), 32'd1);
    chk("rst_in1_ready", 32'(in1.ready), 32'd1);

    @(posedge clk); #1 tile_en = 1'b0;
    @(negedge clk);
    chk("tile_off_in0_ready", 32'(in0.ready), 32'd0);
    @(posedge clk); #1 tile_en = 1'b1;

    run_case(bi, bo, bi, b1, 0, 0);
    run_case(ei, eo, ei, e1x, 0, 0);
    rdy_pct = 50;
    run_case(bi, bo, bi, b1, 20, 0);
    rdy_pct = 100;

    // Outer stream late: nothing emitted and inner FIFO fills to two.
    foreach (bi[k]) begin exp0.push_back(bi[k]); exp1.push_back(b1[k]); end
    fork
      drive(0, bi, 0, 0);
      drive(1, bo, 0, 20);
      begin
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("skew_no_emit", 32'(out0.valid), 32'd0);
        chk("skew_in0_ready", 32'(in0.ready), 32'd0);
      end
    join
    drain();

    // Flush with outputs stalled and tokens buffered everywhere.
    mon_en = 1'b0; rdy_pct = 0;
    @(posedge clk);
    begin
      tok_t fi[$] = '{17'h2, 17'h5, 17'h10000};
      tok_t fo[$] = '{17'h0, 17'h1};
      fork drive(0, fi, 0, 0); drive(1, fo, 0, 0); join
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("preflush_valid", 32'(out0.valid), 32'd1);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_out0_valid", 32'(out0.valid), 32'd0);
    chk("flush_out1_valid", 32'(out1.valid), 32'd0);
    chk("flush_out0_data", 32'(out0.data), 32'd0);
    chk("flush_in0_ready", 32'(in0.ready), 32'd1);
    rdy_pct = 100; mon_en = 1'b1;
    run_case(bi, bo, bi, b1, 0, 0);

    gi.delete(); go.delete();
    for (int k = 0; k < 100; k++) gi.push_back(tok_t'(k + 1));
    gi.push_back(17'h10001); gi.push_back(TD);
    go.push_back(17'h55); go.push_back(17'h10000); go.push_back(TD);
    model(gi, go, m0, m1);
    tp_arm = 1'b1; tp_first = -1; tp_last = -1; tp_cnt = 0;
    run_case(gi, go, m0, m1, 0, 0);
    tp_arm = 1'b0;
    checks++;
    if (tp_last < 0 || tp_first < 0 || (tp_last - tp_first) >= 102) begin
      failures++;
      $display("FAIL throughput actual_span=%0d required_below=102", tp_last - tp_first);
    end

    for (int t = 0; t < 8; t++) begin
      gen(gi, go);
      model(gi, go, m0, m1);
      rdy_pct = (t % 2 == 0) ? 50 : 100;
      run_case(gi, go, m0, m1, 30, $urandom_range(0, 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
